// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, matrix geometry and key decode helpers for the
// 4x3 keypad scanner.
package keypad_pkg;

   localparam int KEY_ROWS = 4;
   localparam int KEY_COLS = 3;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [9:0] onehot;
      logic       star;
      logic       hash;
   } key_code_t;

   // Row 3 carries "* 0 #"; rows 0-2 carry digits 1-9 in reading order.
   function automatic key_code_t key_decode(input logic [1:0] row, input logic [1:0] col);
      key_code_t k;
      k = '0;
      case (row)
         2'd3: begin
            case (col)
               2'd0:    k.star   = 1'b1;
               2'd1:    k.onehot = 10'b1000000000;
               2'd2:    k.hash   = 1'b1;
               default: k        = '0;
            endcase
         end
         default: begin
            if (col < 2'd3) begin
               k.onehot = 10'b0000000001 << ({2'b00, row} * 4'd3 + {2'b00, col});
            end else begin
               k = '0;
            end
         end
      endcase
      return k;
   endfunction

   function automatic logic one_low(input logic [KEY_ROWS-1:0] rs);
      logic r;
      case (rs)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
         default:                           r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] low_index(input logic [KEY_ROWS-1:0] rs);
      logic [1:0] r;
      case (rs)
         4'b1101: r = 2'd1;
         4'b1011: r = 2'd2;
         4'b0111: r = 2'd3;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] next_col(input logic [1:0] c);
      return (c >= 2'(KEY_COLS - 1)) ? 2'd0 : c + 2'd1;
   endfunction

   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/keypad_if.sv
// keypad_if: matrix drive/sense lines plus the decoded key outputs.
interface keypad_if;
   import keypad_pkg::*;

   logic [KEY_ROWS-1:0] row_n;
   logic [KEY_COLS-1:0] col_n;
   logic [9:0]          keypad;
   logic                key_strobe;
   logic                star_pulse;
   logic                hash_pulse;
   logic                busy;

   modport master (
      input  row_n,
      output col_n, keypad, key_strobe, star_pulse, hash_pulse, busy
   );

   modport slave (
      output row_n,
      input  col_n, keypad, key_strobe, star_pulse, hash_pulse, busy
   );

endinterface

// File: rtl/keypad_sync.sv
// keypad_sync: two-flop synchronizer for the asynchronous row inputs,
// resetting to all-high (no key).
module keypad_sync
   import keypad_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [KEY_ROWS-1:0] d,
   output logic [KEY_ROWS-1:0] q
);

   logic [KEY_ROWS-1:0] meta_r;
   logic [KEY_ROWS-1:0] sync_r;

   // Two-stage metastability filter.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_r <= {KEY_ROWS{1'b1}};
         sync_r <= {KEY_ROWS{1'b1}};
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanned 4x3 keypad with press/release debounce.
// Auto-repeat of held digit keys is built only when KEYPAD_REPEAT_EN is defined.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DWELL      = 4,
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int REPEAT_DELAY    = 64,
   parameter int REPEAT_RATE     = 16
) (
   input  logic     clk,
   input  logic     reset,
   keypad_if.master kp
);

   localparam int CNT_W = cnt_width(SCAN_DWELL, DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t DWELL_LAST = cnt_t'(SCAN_DWELL - 1);
   localparam cnt_t DEB_LAST   = cnt_t'(DEBOUNCE_CYCLES - 1);

   function automatic cnt_t sat_inc(input cnt_t v);
      return (&v) ? v : v + cnt_t'(1);
   endfunction

   logic [KEY_ROWS-1:0] rs_s;
   key_code_t           code_s;

   state_t     state_r,   state_s;
   logic [1:0] col_r,     col_s;
   logic [1:0] row_r,     row_s;
   logic [3:0] pat_r,     pat_s;
   cnt_t       dwell_r,   dwell_s;
   cnt_t       cnt_r,     cnt_s;
   logic [2:0] col_n_r,   col_n_s;
   logic [9:0] keypad_r,  keypad_s;
   logic       strobe_r,  strobe_s;
   logic       star_r,    star_s;
   logic       hash_r,    hash_s;
   logic       busy_r,    busy_s;
`ifdef KEYPAD_REPEAT_EN
   localparam cnt_t DELAY_LAST = cnt_t'(REPEAT_DELAY - 1);
   localparam cnt_t RATE_LAST  = cnt_t'(REPEAT_RATE - 1);
   cnt_t       rep_cnt_r, rep_cnt_s;
   logic       rep_first_r, rep_first_s;
`endif

   keypad_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (kp.row_n),
      .q     (rs_s)
   );

   assign code_s = key_decode(row_r, col_r);

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= SCAN;
         col_r    <= 2'd0;
         row_r    <= 2'd0;
         pat_r    <= 4'b1111;
         dwell_r  <= '0;
         cnt_r    <= '0;
         col_n_r  <= 3'b110;
         keypad_r <= 10'd0;
         strobe_r <= 1'b0;
         star_r   <= 1'b0;
         hash_r   <= 1'b0;
         busy_r   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt_r   <= '0;
         rep_first_r <= 1'b0;
`endif
      end else begin
         state_r  <= state_s;
         col_r    <= col_s;
         row_r    <= row_s;
         pat_r    <= pat_s;
         dwell_r  <= dwell_s;
         cnt_r    <= cnt_s;
         col_n_r  <= col_n_s;
         keypad_r <= keypad_s;
         strobe_r <= strobe_s;
         star_r   <= star_s;
         hash_r   <= hash_s;
         busy_r   <= busy_s;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt_r   <= rep_cnt_s;
         rep_first_r <= rep_first_s;
`endif
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_s  = state_r;
      col_s    = col_r;
      row_s    = row_r;
      pat_s    = pat_r;
      dwell_s  = dwell_r;
      cnt_s    = cnt_r;
      keypad_s = keypad_r;
      strobe_s = 1'b0;
      star_s   = 1'b0;
      hash_s   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_s   = rep_cnt_r;
      rep_first_s = rep_first_r;
`endif
      case (state_r)
         SCAN: begin
            keypad_s = 10'd0;
            if (dwell_r >= DWELL_LAST) begin
               dwell_s = '0;
               if (one_low(rs_s)) begin
                  state_s = DEBOUNCE;
                  row_s   = low_index(rs_s);
                  pat_s   = rs_s;
                  cnt_s   = '0;
               end else begin
                  col_s = next_col(col_r);
               end
            end else begin
               dwell_s = sat_inc(dwell_r);
            end
         end
         DEBOUNCE: begin
            if (rs_s == pat_r) begin
               if (cnt_r >= DEB_LAST) begin
                  state_s  = HELD;
                  cnt_s    = '0;
                  keypad_s = code_s.onehot;
                  strobe_s = |code_s.onehot;
                  star_s   = code_s.star;
                  hash_s   = code_s.hash;
`ifdef KEYPAD_REPEAT_EN
                  rep_cnt_s   = '0;
                  rep_first_s = 1'b0;
`endif
               end else begin
                  cnt_s = sat_inc(cnt_r);
               end
            end else begin
               state_s = SCAN;
               col_s   = next_col(col_r);
               dwell_s = '0;
               cnt_s   = '0;
            end
         end
         HELD: begin
            if (rs_s == 4'b1111) begin
               state_s = RELEASE;
               cnt_s   = '0;
            end else begin
`ifdef KEYPAD_REPEAT_EN
               // First repeat waits REPEAT_DELAY, later ones REPEAT_RATE.
               if (|code_s.onehot) begin
                  if (rep_cnt_r >= (rep_first_r ? RATE_LAST : DELAY_LAST)) begin
                     strobe_s    = 1'b1;
                     rep_cnt_s   = '0;
                     rep_first_s = 1'b1;
                  end else begin
                     rep_cnt_s = sat_inc(rep_cnt_r);
                  end
               end else begin
                  rep_cnt_s = rep_cnt_r;
               end
`else
               state_s = HELD;
`endif
            end
         end
         RELEASE: begin
            if (rs_s[row_r] == 1'b0) begin
               state_s = HELD;
               cnt_s   = '0;
`ifdef KEYPAD_REPEAT_EN
               rep_cnt_s   = '0;
               rep_first_s = 1'b0;
`endif
            end else if (rs_s == 4'b1111) begin
               if (cnt_r >= DEB_LAST) begin
                  state_s  = SCAN;
                  keypad_s = 10'd0;
                  col_s    = next_col(col_r);
                  dwell_s  = '0;
                  cnt_s    = '0;
               end else begin
                  cnt_s = sat_inc(cnt_r);
               end
            end else begin
               cnt_s = cnt_r;
            end
         end
         default: begin
            state_s  = SCAN;
            col_s    = 2'd0;
            dwell_s  = '0;
            cnt_s    = '0;
            keypad_s = 10'd0;
         end
      endcase
      col_n_s = ~(3'b001 << col_s);
      busy_s  = (state_s != SCAN);
   end

   assign kp.col_n      = col_n_r;
   assign kp.keypad     = keypad_r;
   assign kp.key_strobe = strobe_r;
   assign kp.star_pulse = star_r;
   assign kp.hash_pulse = hash_r;
   assign kp.busy       = busy_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed test of keypad_scanner against a behavioural
// key matrix; expected values are hand-derived for SCAN_DWELL=4, DEBOUNCE_CYCLES=8.
module tb_keypad_scanner;
   import keypad_pkg::*;

   logic        clk;
   logic        reset;
   logic [11:0] keys;
   logic [3:0]  row_v;
   int          vectors;
   int          miscompares;
   int          strobe_tot;
   int          star_tot;
   int          hash_tot;
   int          base;

   keypad_if kp ();

   keypad_scanner #(
      .SCAN_DWELL      (4),
      .DEBOUNCE_CYCLES (8),
      .REPEAT_DELAY    (64),
      .REPEAT_RATE     (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .kp    (kp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Passive matrix: a pressed key pulls its row low while its column is driven.
   always_comb begin
      row_v = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (keys[r*3+c] && (kp.col_n[c] == 1'b0)) row_v[r] = 1'b0;
         end
      end
   end
   assign kp.row_n = row_v;

   initial begin
      strobe_tot = 0;
      star_tot   = 0;
      hash_tot   = 0;
   end

   always @(negedge clk) begin
      if (kp.key_strobe === 1'b1) strobe_tot = strobe_tot + 1;
      if (kp.star_pulse === 1'b1) star_tot = star_tot + 1;
      if (kp.hash_pulse === 1'b1) hash_tot = hash_tot + 1;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors = vectors + 1;
      assert (obs === exp) else begin
         miscompares = miscompares + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      keys        = 12'd0;
      reset       = 1'b1;

      // Reset and idle column rotation.
      tick(3);
      chk("reset_col_n", 32'(kp.col_n), 32'(3'b110));
      chk("reset_keypad", 32'(kp.keypad), 32'd0);
      chk("reset_busy", 32'(kp.busy), 32'd0);
      chk("reset_strobe", 32'(kp.key_strobe), 32'd0);
      reset = 1'b0;
      tick(1);
      chk("idle_col0", 32'(kp.col_n), 32'(3'b110));
      tick(3);
      chk("idle_col1", 32'(kp.col_n), 32'(3'b101));
      tick(4);
      chk("idle_col2", 32'(kp.col_n), 32'(3'b011));
      tick(4);
      chk("idle_wrap", 32'(kp.col_n), 32'(3'b110));
      chk("idle_busy", 32'(kp.busy), 32'd0);

      // Clean press of "1".
      base = strobe_tot;
      keys[0] = 1'b1;
      tick(40);
      chk("k1_strobes", 32'(strobe_tot - base), 32'd1);
      chk("k1_keypad", 32'(kp.keypad), 32'h001);
      chk("k1_busy", 32'(kp.busy), 32'd1);
      keys[0] = 1'b0;
      tick(4);
      chk("k1_rel_hold", 32'(kp.keypad), 32'h001);
      tick(20);
      chk("k1_rel_clear", 32'(kp.keypad), 32'd0);
      chk("k1_rel_busy", 32'(kp.busy), 32'd0);

      // Digit 0, then '#' and '*'.
      keys[10] = 1'b1;
      tick(40);
      chk("k0_keypad", 32'(kp.keypad), 32'h200);
      keys[10] = 1'b0;
      tick(30);
      chk("k0_clear", 32'(kp.keypad), 32'd0);
      base = strobe_tot;
      keys[11] = 1'b1;
      tick(40);
      chk("hash_pulses", 32'(hash_tot), 32'd1);
      chk("hash_keypad", 32'(kp.keypad), 32'd0);
      chk("hash_no_strobe", 32'(strobe_tot - base), 32'd0);
      chk("hash_busy", 32'(kp.busy), 32'd1);
      keys[11] = 1'b0;
      tick(30);
      keys[9] = 1'b1;
      tick(40);
      chk("star_pulses", 32'(star_tot), 32'd1);
      chk("star_keypad", 32'(kp.keypad), 32'd0);
      keys[9] = 1'b0;
      tick(30);

      // "4" with press bounce and release bounce.
      base = strobe_tot;
      for (int i = 0; i < 3; i++) begin
         keys[3] = 1'b1;
         tick(2);
         keys[3] = 1'b0;
         tick(2);
      end
      keys[3] = 1'b1;
      tick(40);
      chk("k4_bounce_strobes", 32'(strobe_tot - base), 32'd1);
      chk("k4_keypad", 32'(kp.keypad), 32'h008);
      keys[3] = 1'b0;
      tick(3);
      keys[3] = 1'b1;
      tick(12);
      chk("k4_relbounce_keypad", 32'(kp.keypad), 32'h008);
      keys[3] = 1'b0;
      tick(30);
      chk("k4_relbounce_strobes", 32'(strobe_tot - base), 32'd1);
      chk("k4_clear", 32'(kp.keypad), 32'd0);

      // "1" and "4" together in one column are rejected until "1" lifts.
      base = strobe_tot;
      keys[0] = 1'b1;
      keys[3] = 1'b1;
      tick(40);
      chk("ghost_strobes", 32'(strobe_tot - base), 32'd0);
      chk("ghost_keypad", 32'(kp.keypad), 32'd0);
      keys[0] = 1'b0;
      tick(40);
      chk("ghost_after_strobes", 32'(strobe_tot - base), 32'd1);
      chk("ghost_after_keypad", 32'(kp.keypad), 32'h008);
      keys[3] = 1'b0;
      tick(30);

      // Reset while holding "5".
      keys[4] = 1'b1;
      tick(40);
      chk("k5_keypad", 32'(kp.keypad), 32'h010);
      reset = 1'b1;
      tick(1);
      chk("midreset_keypad", 32'(kp.keypad), 32'd0);
      chk("midreset_col_n", 32'(kp.col_n), 32'(3'b110));
      chk("midreset_busy", 32'(kp.busy), 32'd0);
      chk("midreset_strobe", 32'(kp.key_strobe), 32'd0);
      keys[4] = 1'b0;
      tick(2);
      reset = 1'b0;
      tick(5);

      // Long hold of "5": repeat strobes only when the feature is built in.
      base = strobe_tot;
      keys[4] = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (strobe_tot == base) tick(1);
      end
      chk("k5_first_strobe", 32'(strobe_tot - base), 32'd1);
      tick(90);
`ifdef KEYPAD_REPEAT_EN
      chk("k5_hold_strobes", 32'(strobe_tot - base), 32'd3);
`else
      chk("k5_hold_strobes", 32'(strobe_tot - base), 32'd1);
`endif
      chk("k5_hold_keypad", 32'(kp.keypad), 32'h010);
      keys[4] = 1'b0;
      tick(30);
      chk("k5_release", 32'(kp.keypad), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
